// File: rtl/sync_fifo_rw_if.sv
// Writer/reader bundle for sync_fifo_rw.
// master: the producer/consumer side that drives wr_en, wr_data and rd_en.
// slave: the FIFO itself, which drives full, empty, count and rd_data.
interface sync_fifo_rw_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int AW = $clog2(DEPTH);

    // Handshake: a push happens on a rising edge when wr_en=1 and
    // (full=0 or rd_en=1). A pop happens on a rising edge when rd_en=1 and
    // empty=0. rd_data always shows the head word and is meaningful only
    // while empty=0. Requests that are not accepted leave no trace.
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             full;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             empty;
    logic [AW:0]      count;

    modport master (
        output wr_en, wr_data, rd_en,
        input  full, rd_data, empty, count
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output full, rd_data, empty, count
    );
endinterface

// File: rtl/sync_fifo_rw.sv
// sync_fifo_rw: single-clock show-ahead FIFO built from enable-gated flops,
// circular read/write pointers and an occupancy counter.
// Optional feature macro: SYNC_FIFO_ERR_EN adds a sticky err output that
// records any overflow or underflow attempt until the next reset.
module sync_fifo_rw #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic clk,
    input  logic rst,
`ifdef SYNC_FIFO_ERR_EN
    output logic err,
`endif
    sync_fifo_rw_if.slave bus
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             full, empty, push, pop;

    // Flags come straight from the registered count, so wr_en/wr_data
    // never reach the flags or rd_data combinationally.
    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));

    // A full FIFO still accepts a write when the head leaves on the same edge.
    assign push = bus.wr_en & (~full | bus.rd_en);
    assign pop  = bus.rd_en & ~empty;

    assign bus.empty   = empty;
    assign bus.full    = full;
    assign bus.count   = count_q;
    assign bus.rd_data = mem_q[rd_ptr_q];

    // Next pointer and occupancy; pointers wrap naturally since DEPTH is 2^AW.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)      count_d = count_q + (AW+1)'(1);
        else if (pop && !push) count_d = count_q - (AW+1)'(1);
    end

    // Next storage contents: only the entry under wr_ptr changes, on a push.
    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = bus.wr_data;
    end

    // Storage is deliberately not reset; stale words are hidden by empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Pointer and count registers; reset discards all queued data at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef SYNC_FIFO_ERR_EN
    logic err_q, err_d;

    // Sticky error: set by a dropped write or a read of an empty FIFO.
    always_comb begin
        err_d = err_q;
        if (bus.wr_en && full && !bus.rd_en)  err_d = 1'b1;
        if (bus.rd_en && empty && !bus.wr_en) err_d = 1'b1;
    end

    // Error flag register; only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_q <= 1'b0;
        else      err_q <= err_d;
    end

    assign err = err_q;
`endif
endmodule

// File: doc/sync_fifo_rw.md
Name: sync_fifo_rw

Overview:
- Single-clock FIFO with a writer port and a reader port. The writer pushes words in with a write enable; the reader pops them out in arrival order.
- Storage is an array of enable-gated flops, DEPTH entries deep. Circular read/write pointers and an occupancy count sit around the array.
- Used as the buffering stage between a producer datapath and a consumer datapath in the lab designs.

Parameters:
- WIDTH, 8, data word width in bits (≥1).
- DEPTH, 4, number of entries; power of two, ≥2.
- AW, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- wr_en  input  1  writer push request.
- wr_data  input  WIDTH  word to push.
- full  output  1  FIFO holds DEPTH words.
- rd_en  input  1  reader pop request.
- rd_data  output  WIDTH  head word (show-ahead); valid only while empty=0.
- empty  output  1  FIFO holds 0 words.
- count  output  AW+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (rst=0, asynchronous, no clock needed):
  - wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0.
  - Storage contents are not cleared; rd_data is don't-care while empty.
- Accept rules, evaluated from pre-edge state:
  - push = wr_en & (~full | rd_en).
  - pop = rd_en & ~empty.
- On push: mem[wr_ptr] <= wr_data; wr_ptr <= wr_ptr+1, wrapping modulo DEPTH (DEPTH-1 -> 0).
- On pop: rd_ptr <= rd_ptr+1, wrapping modulo DEPTH.
- count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on both or neither.
- empty = (count==0) and full = (count==DEPTH); both derived from registered count, no extra cycle of latency.
- rd_data = mem[rd_ptr], combinational from registered state. A word written at edge N is visible on rd_data after edge N when it is the head, i.e. write-to-read latency is 1 cycle.
- Simultaneous events:
  - Empty with wr_en & rd_en: the write is accepted, the read is ignored, and count becomes 1.
  - Full with wr_en & rd_en: both are accepted, the head is replaced in order, and count stays DEPTH.
  - Partially filled with both: both are accepted and count is unchanged.
- Overflow (wr_en & full & ~rd_en): the write is dropped; pointers, count and storage are unchanged.
- Underflow (rd_en & empty & ~wr_en): no state change.
- Reset mid-operation: all queued data is discarded at once; the first post-reset write lands at entry 0.
- No combinational path from wr_en/wr_data to rd_data or the flags.

Optional Feature:
- Macro: SYNC_FIFO_ERR_EN.
- Defined:
  - Adds output err (1 bit).
  - err is sticky; it sets on the edge after an overflow or underflow attempt, as defined above.
  - Reset (rst=0) is the only way to clear it; reset value 0.
- Undefined:
  - No err port and no error-tracking logic.
  - Overflow and underflow attempts are silently ignored as specified.

Test Plan:
- Reset then idle: after releasing rst (0->1), empty=1, full=0, count=0 across 5 idle cycles.
- Fill and drain: write 0x11,0x22,0x33,0x44 on consecutive cycles -> full=1, count=4. Then rd_en for 4 cycles -> rd_data reads 0x11,0x22,0x33,0x44, and empty=1 after the 4th pop.
- Overflow: with the FIFO full, write 0x55 with rd_en=0 -> count stays 4 and the next reads return 0x11..0x44 (0x55 absent). With SYNC_FIFO_ERR_EN, err=1 on the next cycle and holds until reset.
- Simultaneous read/write:
  - Empty case: write 0xA5 with rd_en=1 -> count=1, rd_data=0xA5.
  - Full case: write 0x66 with rd_en=1 -> count stays 4 and the pop order ends ...,0x44,0x66.
- Wrap-around: run 10 alternating single write/read pairs with data 0..9 -> each rd_data matches its write, count toggles 1/0, and pointers wrap cleanly past index 3.
- Async reset mid-stream: load 3 words, then drive rst=0 between clock edges -> empty=1 and count=0 immediately, without waiting for an edge. After release, write 0x77 -> rd_data=0x77 and count=1.
